// File: rtl/btn_evt_pkg.sv
// Shared encodings and helpers for the button event scheduler.
package btn_evt_pkg;

  localparam logic [1:0] KIND_PRESS   = 2'b01;
  localparam logic [1:0] KIND_LONG    = 2'b11;
  localparam logic [1:0] KIND_RELEASE = 2'b10;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_OFFER = 1'b1
  } state_e;

  // Returns {drop, next}: a new event on an occupied bit is dropped unless that bit is being granted.
  function automatic logic [1:0] pend_next(input logic pend, input logic set, input logic clr);
    pend_next = {set & pend & ~clr, set | (pend & ~clr)};
  endfunction

endpackage

// File: rtl/btn_evt_tracker.sv
// Per-button edge/long-hold detection with one pending bit per event kind.
module btn_evt_tracker
  import btn_evt_pkg::*;
#(
  parameter int unsigned LONG_CYC = 2000
) (
  input  logic clk,
  input  logic rst,
  input  logic lvl_in,
  input  logic clr_p,
  input  logic clr_l,
  input  logic clr_r,
  output logic pend_p,
  output logic pend_l,
  output logic pend_r,
  output logic ovf_c
);

  localparam int unsigned CW = $clog2(LONG_CYC + 1);

  logic          lvl_q, lvl_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_p_q, pend_p_d;
  logic          pend_l_q, pend_l_d;
  logic          pend_r_q, pend_r_d;
  logic          press, rel, long_ev;
  logic [1:0]    nx_p, nx_l, nx_r;

  always_comb begin
    press   = lvl_in & ~lvl_q;
    rel     = ~lvl_in & lvl_q;
    // Counter saturates, so the LONG_CYC-1 -> LONG_CYC step happens once per hold.
    long_ev = lvl_in & (cnt_q == CW'(LONG_CYC - 1));
    lvl_d   = lvl_in;
    cnt_d   = '0;
    if (lvl_in) begin
      cnt_d = (cnt_q == CW'(LONG_CYC)) ? cnt_q : cnt_q + CW'(1);
    end
    nx_p     = pend_next(pend_p_q, press,   clr_p);
    nx_l     = pend_next(pend_l_q, long_ev, clr_l);
    nx_r     = pend_next(pend_r_q, rel,     clr_r);
    pend_p_d = nx_p[0];
    pend_l_d = nx_l[0];
    pend_r_d = nx_r[0];
    ovf_c    = nx_p[1] | nx_l[1] | nx_r[1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl_q    <= 1'b0;
      cnt_q    <= '0;
      pend_p_q <= 1'b0;
      pend_l_q <= 1'b0;
      pend_r_q <= 1'b0;
    end else begin
      lvl_q    <= lvl_d;
      cnt_q    <= cnt_d;
      pend_p_q <= pend_p_d;
      pend_l_q <= pend_l_d;
      pend_r_q <= pend_r_d;
    end
  end

  assign pend_p = pend_p_q;
  assign pend_l = pend_l_q;
  assign pend_r = pend_r_q;

endmodule

// File: rtl/btn_event_sched.sv
// Turns debounced button levels into press/long/release events, arbitrated round-robin onto one valid/ready port.
module btn_event_sched
  import btn_evt_pkg::*;
#(
  parameter  int unsigned N_BTN    = 4,
  parameter  int unsigned LONG_CYC = 2000,
  localparam int unsigned IDW      = $clog2(N_BTN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_lvl,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [IDW-1:0]   evt_id,
  output logic [1:0]       evt_kind,
  output logic [N_BTN-1:0] ovf,
  input  logic             ovf_clr
);

  logic [N_BTN-1:0] pend_p, pend_l, pend_r;
  logic [N_BTN-1:0] gnt_p, gnt_l, gnt_r;
  logic [N_BTN-1:0] ovf_c;

  state_e           state_q, state_d;
  logic             valid_q, valid_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [1:0]       kind_q, kind_d;
  logic [IDW-1:0]   rr_q, rr_d;
  logic [N_BTN-1:0] ovf_q, ovf_d;
  logic [IDW-1:0]   cand, sel;
  logic             found;

  for (genvar i = 0; i < N_BTN; i++) begin : g_trk
    btn_evt_tracker #(.LONG_CYC(LONG_CYC)) u_trk (
      .clk    (clk),
      .rst    (rst),
      .lvl_in (btn_lvl[i]),
      .clr_p  (gnt_p[i]),
      .clr_l  (gnt_l[i]),
      .clr_r  (gnt_r[i]),
      .pend_p (pend_p[i]),
      .pend_l (pend_l[i]),
      .pend_r (pend_r[i]),
      .ovf_c  (ovf_c[i])
    );
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    id_d    = id_q;
    kind_d  = kind_q;
    rr_d    = rr_q;
    gnt_p   = '0;
    gnt_l   = '0;
    gnt_r   = '0;
    cand    = '0;
    sel     = '0;
    found   = 1'b0;
    // Round-robin search upward from rr_q, wrapping at N_BTN.
    for (int unsigned k = 0; k < N_BTN; k++) begin
      cand = IDW'((32'(rr_q) + k) % N_BTN);
      if (!found && (pend_p[cand] | pend_l[cand] | pend_r[cand])) begin
        found = 1'b1;
        sel   = cand;
      end
    end
    case (state_q)
      S_IDLE: begin
        if (found) begin
          id_d    = sel;
          valid_d = 1'b1;
          state_d = S_OFFER;
          if (pend_p[sel]) begin
            kind_d     = KIND_PRESS;
            gnt_p[sel] = 1'b1;
          end else if (pend_l[sel]) begin
            kind_d     = KIND_LONG;
            gnt_l[sel] = 1'b1;
          end else begin
            kind_d     = KIND_RELEASE;
            gnt_r[sel] = 1'b1;
          end
        end
      end
      S_OFFER: begin
        if (evt_ready) begin
          valid_d = 1'b0;
          rr_d    = IDW'((32'(id_q) + 32'd1) % N_BTN);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A drop in the same cycle as ovf_clr must survive the clear.
    ovf_d = (ovf_clr ? '0 : ovf_q) | ovf_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      id_q    <= '0;
      kind_q  <= 2'b00;
      rr_q    <= '0;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      kind_q  <= kind_d;
      rr_q    <= rr_d;
      ovf_q   <= ovf_d;
    end
  end

  assign evt_valid = valid_q;
  assign evt_id    = id_q;
  assign evt_kind  = kind_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_btn_event_sched.sv
// Self-checking bench for btn_event_sched: event-level model plus directed scenarios.
module tb_btn_event_sched;

  localparam int N    = 4;
  localparam int LONG = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] btn_lvl = '0;
  logic         evt_ready = 1'b0;
  logic         ovf_clr = 1'b0;
  logic         evt_valid;
  logic [1:0]   evt_id;
  logic [1:0]   evt_kind;
  logic [N-1:0] ovf;

  int errors = 0;
  int checks = 0;

  btn_event_sched #(.N_BTN(N), .LONG_CYC(LONG)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_lvl   (btn_lvl),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_id    (evt_id),
    .evt_kind  (evt_kind),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  function automatic int ev(input int id, input int kind);
    return id * 4 + kind;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Event-level model: per-button pending flags, one offered event, round-robin pointer.
  bit m_prev [N];
  int m_hold [N];
  bit m_pp [N];
  bit m_pl [N];
  bit m_pr [N];
  bit m_valid;
  int m_id, m_kind, m_rr;
  bit [N-1:0] m_ovf;
  int acc_q[$];
  int exp_q[$];

  // Returns {drop, next} for one pending flag.
  function automatic bit [1:0] flag_next(input bit p, input bit e, input bit g);
    if (e) return {p && !g, 1'b1};
    if (g) return 2'b00;
    return {1'b0, p};
  endfunction

  always @(posedge clk or posedge rst) begin
    int g, gk, b;
    bit pe, re, le;
    bit [1:0] r;
    bit [N-1:0] nov;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_prev[i] = 0; m_hold[i] = 0; m_pp[i] = 0; m_pl[i] = 0; m_pr[i] = 0;
      end
      m_valid = 0; m_id = 0; m_kind = 0; m_rr = 0; m_ovf = '0;
    end else begin
      g = -1; gk = 0;
      if (m_valid) begin
        if (evt_ready) begin
          acc_q.push_back(ev(m_id, m_kind));
          m_valid = 0;
          m_rr = (m_id + 1) % N;
        end
      end else begin
        for (int k = 0; k < N; k++) begin
          b = (m_rr + k) % N;
          if (g < 0 && (m_pp[b] || m_pl[b] || m_pr[b])) g = b;
        end
        if (g >= 0) begin
          gk = m_pp[g] ? 1 : (m_pl[g] ? 3 : 2);
          m_valid = 1; m_id = g; m_kind = gk;
        end
      end
      nov = '0;
      for (int i = 0; i < N; i++) begin
        pe = btn_lvl[i] && !m_prev[i];
        re = !btn_lvl[i] && m_prev[i];
        le = btn_lvl[i] && (m_hold[i] == LONG - 1);
        r = flag_next(m_pp[i], pe, g == i && gk == 1); m_pp[i] = r[0]; nov[i] |= r[1];
        r = flag_next(m_pl[i], le, g == i && gk == 3); m_pl[i] = r[0]; nov[i] |= r[1];
        r = flag_next(m_pr[i], re, g == i && gk == 2); m_pr[i] = r[0]; nov[i] |= r[1];
        m_hold[i] = btn_lvl[i] ? ((m_hold[i] < LONG) ? m_hold[i] + 1 : LONG) : 0;
        m_prev[i] = btn_lvl[i];
      end
      m_ovf = (ovf_clr ? '0 : m_ovf) | nov;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("cyc_valid", int'(evt_valid), int'(m_valid));
    if (m_valid) begin
      chk("cyc_id", int'(evt_id), m_id);
      chk("cyc_kind", int'(evt_kind), m_kind);
    end
    chk("cyc_ovf", int'(ovf), int'(m_ovf));
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_events(input string name);
    chk({name, "_count"}, acc_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++)
      chk({name, "_evt"}, acc_q[i], exp_q[i]);
    acc_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    acc_q.delete();
  endtask

  initial begin
    step(3);
    chk("rst_valid", int'(evt_valid), 0);
    chk("rst_id", int'(evt_id), 0);
    chk("rst_kind", int'(evt_kind), 0);
    chk("rst_ovf", int'(ovf), 0);
    rst = 1'b0;
    acc_q.delete();
    step(2);

    // Single short press on button 2
    evt_ready = 1'b1;
    btn_lvl[2] = 1'b1;
    step(1);
    chk("t1_lat_e0", int'(evt_valid), 0);
    step(1);
    chk("t1_lat_e1", int'(evt_valid), 1);
    chk("t1_id", int'(evt_id), 2);
    chk("t1_kind", int'(evt_kind), 1);
    step(8);
    btn_lvl[2] = 1'b0;
    step(6);
    exp_q = '{ev(2, 1), ev(2, 2)};
    chk_events("t1");
    chk("t1_ovf", int'(ovf), 0);

    // Long hold on button 0
    do_reset();
    btn_lvl[0] = 1'b1;
    step(40);
    btn_lvl[0] = 1'b0;
    step(6);
    exp_q = '{ev(0, 1), ev(0, 3), ev(0, 2)};
    chk_events("t2");

    // All buttons at once, twice
    do_reset();
    btn_lvl = 4'hF;
    step(12);
    btn_lvl = 4'h0;
    step(12);
    btn_lvl = 4'hF;
    step(12);
    btn_lvl = 4'h0;
    step(12);
    exp_q = '{ev(0, 1), ev(1, 1), ev(2, 1), ev(3, 1),
              ev(0, 2), ev(1, 2), ev(2, 2), ev(3, 2),
              ev(0, 1), ev(1, 1), ev(2, 1), ev(3, 1),
              ev(0, 2), ev(1, 2), ev(2, 2), ev(3, 2)};
    chk_events("t3");

    // Back-pressure and overflow on button 1
    do_reset();
    evt_ready = 1'b0;
    for (int t = 0; t < 4; t++) begin
      btn_lvl[1] = (t % 2 == 0);
      for (int c = 0; c < 3; c++) begin
        step(1);
        if (evt_valid) begin
          chk("t4_hold_id", int'(evt_id), 1);
          chk("t4_hold_kind", int'(evt_kind), 1);
        end
      end
    end
    step(2);
    chk("t4_valid", int'(evt_valid), 1);
    chk("t4_ovf", int'(ovf), 2);
    evt_ready = 1'b1;
    step(10);
    exp_q = '{ev(1, 1), ev(1, 1), ev(1, 2)};
    chk_events("t4");
    chk("t4_ovf_kept", int'(ovf), 2);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    chk("t4_ovf_clr", int'(ovf), 0);

    // Button already high when reset releases
    rst = 1'b1;
    btn_lvl[2] = 1'b1;
    step(2);
    rst = 1'b0;
    acc_q.delete();
    step(1);
    chk("t5_e0", int'(evt_valid), 0);
    step(1);
    chk("t5_valid", int'(evt_valid), 1);
    chk("t5_id", int'(evt_id), 2);
    chk("t5_kind", int'(evt_kind), 1);
    step(4);
    btn_lvl[2] = 1'b0;
    step(6);
    exp_q = '{ev(2, 1), ev(2, 2)};
    chk_events("t5");

    // Reset while offering
    evt_ready = 1'b0;
    btn_lvl[0] = 1'b1;
    step(3);
    chk("t6_offer", int'(evt_valid), 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    btn_lvl = '0;
    #1;
    chk("t6_async", int'(evt_valid), 0);
    step(2);
    rst = 1'b0;
    acc_q.delete();
    evt_ready = 1'b1;
    step(10);
    chk("t6_quiet", int'(evt_valid), 0);
    exp_q.delete();
    chk_events("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
